// File: rtl/mul_issue_ctrl_pkg.sv
// rtl/mul_issue_ctrl_pkg.sv - shared multiply op encoding and pipeline latency default
package mul_issue_ctrl_pkg;

  localparam int MUL_LATENCY_DFLT = 5;

  typedef enum logic [1:0] {
    MUL_    = 2'd0,
    MULH_   = 2'd1,
    MULHSU_ = 2'd2,
    MULHU_  = 2'd3
  } mul_ops_e;

endpackage

// File: rtl/mul_tag_pipe.sv
// rtl/mul_tag_pipe.sv - {valid, tag} shift pipeline that mirrors the multiply unit stages
module mul_tag_pipe #(
  parameter int DEPTH = 5,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_shift_en,
  input  logic             i_clear,
  input  logic             i_load_valid,
  input  logic [TAG_W-1:0] i_load_tag,
  output logic [DEPTH-1:0] o_valid,
  output logic [TAG_W-1:0] o_tail_tag
);

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [DEPTH];

  // Clear wins over shift so a flush drops even the entry being loaded.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      if (i_shift_en) begin
        r_valid[0] <= i_load_valid;
        r_tag[0]   <= i_load_tag;
        for (int i = 1; i < DEPTH; i++) begin
          r_valid[i] <= r_valid[i-1];
          r_tag[i]   <= r_tag[i-1];
        end
      end
      if (i_clear) begin
        r_valid <= '0;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_tail_tag = r_tag[DEPTH-1];

endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - issue/stall/flush control and result tagging for a fixed-latency multiplier
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DFLT,
  parameter int TAG_W       = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  mul_ops_e         issue_ops_i,
  input  logic [TAG_W-1:0] issue_rd_i,
  input  logic             flush_i,
  output logic             mul_clk_en_o,
  output mul_ops_e         mul_ops_o,
  output logic             result_valid_o,
  output logic [TAG_W-1:0] result_rd_o,
  input  logic             result_ready_i,
  output logic             busy_o,
  output logic [31:0]      issued_cnt_o
);

  logic [MUL_LATENCY-1:0] w_valid;
  logic [TAG_W-1:0]       w_tail_tag;
  logic                   w_adv;
  logic                   w_accept;
  logic [31:0]            r_issued_cnt;

  // The whole unit freezes only when an unconsumed result sits at the output.
  assign w_adv    = !(w_valid[MUL_LATENCY-1] && !result_ready_i);
  assign w_accept = issue_valid_i && issue_ready_o;

  assign issue_ready_o  = w_adv && !flush_i && rst_n_i;
  assign mul_clk_en_o   = w_adv;
  assign mul_ops_o      = issue_ops_i;
  assign result_valid_o = w_valid[MUL_LATENCY-1];
  assign result_rd_o    = w_tail_tag;
  assign busy_o         = |w_valid;
  assign issued_cnt_o   = r_issued_cnt;

  mul_tag_pipe #(
    .DEPTH (MUL_LATENCY),
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .i_clk        (clk_i),
    .i_rst_n      (rst_n_i),
    .i_shift_en   (w_adv),
    .i_clear      (flush_i),
    .i_load_valid (w_accept),
    .i_load_tag   (issue_rd_i),
    .o_valid      (w_valid),
    .o_tail_tag   (w_tail_tag)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_issued_cnt <= '0;
    end else begin
      r_issued_cnt <= r_issued_cnt + {31'd0, w_accept};
    end
  end

endmodule
